// File: rtl/writeback_retire_unit.sv
// Writeback/retire stage: registered regfile write port, bypass hold, stats.
// Optional macro WB_OVERFLOW_TRAP_EN redirects overflowing writes to STATUS_REG.
module writeback_retire_unit #(
    parameter int unsigned STATUS_REG  = 30,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            write_instruction,
    input  logic [31:0]            write_input_a,
    input  logic [31:0]            write_input_b,
    input  logic [4:0]             write_regfile_write_address,
    input  logic                   write_refile_write_en,
    input  logic                   write_ram_to_register_en,
    input  logic                   write_overflow,
    input  logic                   stall,
    input  logic                   clear_status,
    output logic                   regfile_write_en,
    output logic [4:0]             regfile_write_address,
    output logic [31:0]            regfile_write_data,
    output logic                   hold_valid,
    output logic [4:0]             hold_address,
    output logic [31:0]            hold_data,
    output logic                   sticky_overflow,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic [COUNT_WIDTH-1:0] overflow_count
);

    localparam logic [4:0] STATUS_ADDR = 5'(STATUS_REG);

    logic                   retire;
    logic                   ovf_retire;
    logic [31:0]            sel_data;
    logic                   en_d, en_q;
    logic [4:0]             addr_d, addr_q;
    logic [31:0]            data_d, data_q;
    logic                   hvalid_q;
    logic [4:0]             haddr_q;
    logic [31:0]            hdata_q;
    logic                   sticky_q;
    logic [COUNT_WIDTH-1:0] ret_q, ovf_q;

    assign retire     = !stall && (write_instruction != 32'h0);
    assign ovf_retire = retire && write_overflow;
    assign sel_data   = write_ram_to_register_en ? write_input_b : write_input_a;

`ifdef WB_OVERFLOW_TRAP_EN
    logic        redirect;
    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [31:0] exc_code;

    assign redirect = retire && write_refile_write_en && write_overflow;
    assign opcode   = write_instruction[31:27];
    assign aluop    = write_instruction[6:2];

    // Exception code identifying which arithmetic op overflowed
    always_comb begin
        exc_code = 32'd0;
        unique case (1'b1)
            (opcode == 5'b00000) && (aluop == 5'b00000): exc_code = 32'd1;
            (opcode == 5'b00101):                        exc_code = 32'd2;
            (opcode == 5'b00000) && (aluop == 5'b00001): exc_code = 32'd3;
            default:                                     exc_code = 32'd0;
        endcase
    end
`else
    logic redirect;
    logic unused_status;

    assign redirect      = 1'b0;
    assign unused_status = ^STATUS_ADDR;
`endif

    // Next write-port contents: nothing unless retiring, r0 never enabled
    always_comb begin
        en_d   = 1'b0;
        addr_d = 5'd0;
        data_d = 32'd0;
        if (retire) begin
`ifdef WB_OVERFLOW_TRAP_EN
            addr_d = redirect ? STATUS_ADDR : write_regfile_write_address;
            data_d = redirect ? exc_code : sel_data;
`else
            addr_d = write_regfile_write_address;
            data_d = sel_data;
`endif
            en_d   = write_refile_write_en && (addr_d != 5'd0);
        end
    end

    // Write port, bypass hold, sticky flag and saturating counters
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q     <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= 32'd0;
            hvalid_q <= 1'b0;
            haddr_q  <= 5'd0;
            hdata_q  <= 32'd0;
            sticky_q <= 1'b0;
            ret_q    <= '0;
            ovf_q    <= '0;
        end else begin
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            hvalid_q <= en_q;
            haddr_q  <= addr_q;
            hdata_q  <= data_q;
            if (ovf_retire) begin
                sticky_q <= 1'b1;
            end else if (clear_status) begin
                sticky_q <= 1'b0;
            end
            if (retire && !(&ret_q)) begin
                ret_q <= ret_q + 1'b1;
            end
            if (ovf_retire && !(&ovf_q)) begin
                ovf_q <= ovf_q + 1'b1;
            end
        end
    end

    assign regfile_write_en      = en_q;
    assign regfile_write_address = addr_q;
    assign regfile_write_data    = data_q;
    assign hold_valid            = hvalid_q;
    assign hold_address          = haddr_q;
    assign hold_data             = hdata_q;
    assign sticky_overflow       = sticky_q;
    assign retired_count         = ret_q;
    assign overflow_count        = ovf_q;

endmodule

// File: tb/tb_writeback_retire_unit.sv
// Bench for writeback_retire_unit: directed steps then random traffic
// checked against a behavioural model; COUNT_WIDTH=4 to reach saturation.
module tb_writeback_retire_unit;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [31:0] I_ADD  = 32'h0000_0100;
    localparam logic [31:0] I_SUB  = 32'h0000_0104;
    localparam logic [31:0] I_ADDI = 32'h2800_0000;
    localparam logic [31:0] I_OTH  = 32'h4000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   ins, ina, inb;
    logic [4:0]    wad;
    logic          wen, r2r, ovf, stl, clr;
    logic          o_en, o_hv, o_st;
    logic [4:0]    o_ad, o_ha;
    logic [31:0]   o_dt, o_hd;
    logic [CW-1:0] o_rc, o_oc;

    int checks   = 0;
    int failures = 0;

    // model state
    bit          m_en, m_hv, m_st, m_dc, m_hdc;
    logic [4:0]  m_ad, m_ha;
    logic [31:0] m_dt, m_hd;
    int          m_rc, m_oc;

    always #5 clock = ~clock;

    writeback_retire_unit #(.STATUS_REG(30), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .write_instruction(ins), .write_input_a(ina), .write_input_b(inb),
        .write_regfile_write_address(wad), .write_refile_write_en(wen),
        .write_ram_to_register_en(r2r), .write_overflow(ovf),
        .stall(stl), .clear_status(clr),
        .regfile_write_en(o_en), .regfile_write_address(o_ad),
        .regfile_write_data(o_dt), .hold_valid(o_hv), .hold_address(o_ha),
        .hold_data(o_hd), .sticky_overflow(o_st),
        .retired_count(o_rc), .overflow_count(o_oc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exc_code(input logic [31:0] i);
        if (i[31:27] == 5'd0 && i[6:2] == 5'd0) return 32'd1;
        if (i[31:27] == 5'd5) return 32'd2;
        if (i[31:27] == 5'd0 && i[6:2] == 5'd1) return 32'd3;
        return 32'd0;
    endfunction

    // advance the model by one clock edge using the current inputs
    task automatic model_edge();
        bit ret;
        if (reset) begin
            m_en = 0; m_ad = 0; m_dt = 0; m_hv = 0; m_ha = 0; m_hd = 0;
            m_st = 0; m_rc = 0; m_oc = 0; m_dc = 0; m_hdc = 0;
            return;
        end
        m_hv = m_en; m_ha = m_ad; m_hd = m_dt; m_hdc = m_dc;
        ret = !stl && ins != 0;
        m_en = 0; m_ad = 0; m_dt = 0; m_dc = 0;
        if (ret) begin
            m_ad = wad;
            m_dt = r2r ? inb : ina;
`ifdef WB_OVERFLOW_TRAP_EN
            if (wen && ovf) begin
                m_ad = 5'd30;
                m_dt = exc_code(ins);
            end
`endif
            m_en = wen && m_ad != 0;
            m_dc = !wen;
            if (m_rc < MAXC) m_rc++;
            if (ovf && m_oc < MAXC) m_oc++;
        end
        if (ret && ovf) m_st = 1;
        else if (clr) m_st = 0;
    endtask

    task automatic check_all();
        chk("en", 32'(o_en), 32'(m_en));
        if (!m_dc) begin
            chk("addr", 32'(o_ad), 32'(m_ad));
            chk("data", o_dt, m_dt);
        end
        chk("hold_valid", 32'(o_hv), 32'(m_hv));
        if (!m_hdc) begin
            chk("hold_addr", 32'(o_ha), 32'(m_ha));
            chk("hold_data", o_hd, m_hd);
        end
        chk("sticky", 32'(o_st), 32'(m_st));
        chk("retired", 32'(o_rc), 32'(m_rc));
        chk("ovf_count", 32'(o_oc), 32'(m_oc));
    endtask

    task automatic step(input logic rs, input logic [31:0] i,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ad, input logic we,
                        input logic rr, input logic ov,
                        input logic st, input logic cl);
        reset = rs; ins = i; ina = a; inb = b; wad = ad;
        wen = we; r2r = rr; ovf = ov; stl = st; clr = cl;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rnd_step(input logic rs);
        logic [31:0] i;
        case ($urandom_range(0, 5))
            0: i = 32'h0;
            1: i = I_ADD;
            2: i = I_SUB;
            3: i = I_ADDI;
            default: i = $urandom;
        endcase
        step(rs, i, $urandom, $urandom, 5'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom),
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 1);
    endtask

    initial begin
        // reset with random inputs
        rnd_step(1'b1);
        rnd_step(1'b1);
        chk("rst_en", 32'(o_en), 32'd0);
        chk("rst_data", o_dt, 32'd0);
        chk("rst_retired", 32'(o_rc), 32'd0);
        chk("rst_sticky", 32'(o_st), 32'd0);
        step(0, 32'h0, 32'h55, 32'h66, 5'd3, 1, 0, 0, 0, 0);
        chk("nop_en", 32'(o_en), 32'd0);
        chk("nop_retired", 32'(o_rc), 32'd0);
        // ALU write and hold lag
        step(0, I_OTH, 32'h1234, 32'h9, 5'd5, 1, 0, 0, 0, 0);
        chk("alu_addr", 32'(o_ad), 32'd5);
        chk("alu_data", o_dt, 32'h1234);
        step(0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
        chk("hold_v", 32'(o_hv), 32'd1);
        chk("hold_d", o_hd, 32'h1234);
        chk("ret1", 32'(o_rc), 32'd1);
        // RAM select, zero register
        step(0, I_OTH, 32'h1, 32'hDEAD_BEEF, 5'd7, 1, 1, 0, 0, 0);
        chk("ram_data", o_dt, 32'hDEAD_BEEF);
        step(0, I_OTH, 32'h77, 32'h0, 5'd0, 1, 0, 0, 0, 0);
        chk("r0_en", 32'(o_en), 32'd0);
        chk("r0_ret", 32'(o_rc), 32'd3);
        // overflow
        step(0, I_ADD, 32'h8000_0000, 32'h0, 5'd9, 1, 0, 1, 0, 0);
`ifdef WB_OVERFLOW_TRAP_EN
        chk("add_ovf_addr", 32'(o_ad), 32'd30);
        chk("add_ovf_data", o_dt, 32'd1);
`else
        chk("add_ovf_addr", 32'(o_ad), 32'd9);
        chk("add_ovf_data", o_dt, 32'h8000_0000);
`endif
        chk("ovf_cnt1", 32'(o_oc), 32'd1);
        chk("ovf_sticky", 32'(o_st), 32'd1);
        step(0, I_ADDI, 32'h7, 32'h0, 5'd4, 1, 0, 1, 0, 0);
        step(0, I_SUB, 32'h8, 32'h0, 5'd4, 1, 0, 1, 0, 1);
        chk("clr_set_wins", 32'(o_st), 32'd1);
        step(0, I_OTH, 32'h8, 32'h0, 5'd4, 1, 0, 1, 0, 0);
        step(0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1);
        chk("clr", 32'(o_st), 32'd0);
        // stall with write and overflow
        step(0, I_ADD, 32'h5, 32'h0, 5'd9, 1, 0, 1, 1, 0);
        chk("stall_en", 32'(o_en), 32'd0);
        chk("stall_sticky", 32'(o_st), 32'd0);
        // saturation
        for (int k = 0; k < 20; k++)
            step(0, I_OTH, k, 32'h0, 5'd2, 1, 0, 0, 0, 0);
        chk("sat", 32'(o_rc), 32'hF);
        // reset mid-stream
        step(1, I_OTH, 32'h3, 32'h0, 5'd2, 1, 0, 0, 0, 0);
        chk("mid_rst_en", 32'(o_en), 32'd0);
        // random traffic
        for (int k = 0; k < 400; k++)
            rnd_step($urandom_range(0, 99) < 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
